match_ctrl: RTL and testbench

Round and match sequencer for the two-player flappy-bird game, sitting directly downstream of the game-render stage. It consumes the renderer's one-cycle `winner_valid`/`winner_code` verdict, keeps per-player scores, and drives the renderer's synchronous `game_rst` so birds and tubes only run during live play. It also exposes state, countdown and score information for the HUD/overlay stage.

---
 rtl/match_ctrl.sv | 161 ++++++++++++++++
 tb/tb_match_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// match_ctrl: round/match sequencer for the two-player flappy-bird game.
// Takes the renderer's one-cycle round verdict and keeps both players' scores.
// Holds the renderer in reset except during live play.
// Publishes state, countdown and score information for the HUD.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   start_local/remote        player button levels (clk domain)
//   winner_valid/winner_code  round verdict strobe and code from renderer
//   game_rst                  renderer hold, low only in PLAY
//   state                     0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 ROUND_END, 4 MATCH_END
//   countdown_sec             3/2/1 during COUNTDOWN, else 0
//   ready_local/remote        arming flags in IDLE / MATCH_END
//   score_p1/p2               round wins (saturating)
//   last_result               most recently accepted verdict code
//   match_winner              01/10 once the match is decided, else 00
module match_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 65_000_000,
  parameter int unsigned RESULT_CYCLES = 130_000_000,
  parameter int unsigned WIN_SCORE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_local,
  input  logic       start_remote,
  input  logic       winner_valid,
  input  logic [1:0] winner_code,
  output logic       game_rst,
  output logic [2:0] state,
  output logic [1:0] countdown_sec,
  output logic       ready_local,
  output logic       ready_remote,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] last_result,
  output logic [1:0] match_winner
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned RW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_ROUND_END = 3'd3,
    S_MATCH_END = 3'd4
  } state_t;

  state_t          state_q;
  logic            game_rst_q;
  logic [1:0]      sec_q;
  logic            rdy_l_q, rdy_r_q;
  logic [3:0]      s1_q, s2_q;
  logic [1:0]      last_q, winner_q;
  logic            loc_d_q, rem_d_q;
  logic [TW-1:0]   tick_q;
  logic [RW-1:0]   res_q;

  // Rising-edge detect; delayed copies reset high so a held button is not a start
  logic edge_l_c, edge_r_c, arm_l_c, arm_r_c;
  assign edge_l_c = start_local  & ~loc_d_q;
  assign edge_r_c = start_remote & ~rem_d_q;
  assign arm_l_c  = rdy_l_q | edge_l_c;
  assign arm_r_c  = rdy_r_q | edge_r_c;

  // Sequencer state and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      game_rst_q <= 1'b1;
      sec_q      <= 2'd0;
      rdy_l_q    <= 1'b0;
      rdy_r_q    <= 1'b0;
      s1_q       <= 4'd0;
      s2_q       <= 4'd0;
      last_q     <= 2'b00;
      winner_q   <= 2'b00;
      loc_d_q    <= 1'b1;
      rem_d_q    <= 1'b1;
      tick_q     <= '0;
      res_q      <= '0;
    end else begin
      loc_d_q <= start_local;
      rem_d_q <= start_remote;
      case (state_q)
        S_IDLE, S_MATCH_END: begin
          if (arm_l_c && arm_r_c) begin
            // Both armed: start a countdown; a new match starts from scratch
            rdy_l_q <= 1'b0;
            rdy_r_q <= 1'b0;
            tick_q  <= '0;
            sec_q   <= 2'd3;
            state_q <= S_COUNTDOWN;
            if (state_q == S_MATCH_END) begin
              s1_q     <= 4'd0;
              s2_q     <= 4'd0;
              last_q   <= 2'b00;
              winner_q <= 2'b00;
            end
          end else begin
            rdy_l_q <= arm_l_c;
            rdy_r_q <= arm_r_c;
          end
        end
        S_COUNTDOWN: begin
          if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
            tick_q <= '0;
            if (sec_q == 2'd1) begin
              sec_q      <= 2'd0;
              game_rst_q <= 1'b0;
              state_q    <= S_PLAY;
            end else begin
              sec_q <= sec_q - 2'd1;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_PLAY: begin
          // Code 00 is not a verdict
          if (winner_valid && (winner_code != 2'b00)) begin
            if (winner_code == 2'b01 && s1_q != 4'd15) s1_q <= s1_q + 4'd1;
            if (winner_code == 2'b10 && s2_q != 4'd15) s2_q <= s2_q + 4'd1;
            last_q     <= winner_code;
            game_rst_q <= 1'b1;
            res_q      <= '0;
            state_q    <= S_ROUND_END;
          end
        end
        S_ROUND_END: begin
          if (res_q == RW'(RESULT_CYCLES - 1)) begin
            res_q <= '0;
            if (s1_q == 4'(WIN_SCORE) || s2_q == 4'(WIN_SCORE)) begin
              winner_q <= (s1_q == 4'(WIN_SCORE)) ? 2'b01 : 2'b10;
              state_q  <= S_MATCH_END;
            end else begin
              tick_q  <= '0;
              sec_q   <= 2'd3;
              state_q <= S_COUNTDOWN;
            end
          end else begin
            res_q <= res_q + RW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign game_rst      = game_rst_q;
  assign state         = state_q;
  assign countdown_sec = sec_q;
  assign ready_local   = rdy_l_q;
  assign ready_remote  = rdy_r_q;
  assign score_p1      = s1_q;
  assign score_p2      = s2_q;
  assign last_result   = last_q;
  assign match_winner  = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed, table-driven bench for match_ctrl (TICKS_PER_SEC=4, RESULT_CYCLES=5, WIN_SCORE=2).
module tb_match_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       grst;
    logic [1:0] cd;
    logic       rl;
    logic       rr;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] lr;
    logic [1:0] mw;
  } out_t;

  typedef struct {
    logic       sl;
    logic       sr;
    logic       wv;
    logic [1:0] wc;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_local, start_remote, winner_valid;
  logic [1:0] winner_code;
  logic       game_rst;
  logic [2:0] state;
  logic [1:0] countdown_sec;
  logic       ready_local, ready_remote;
  logic [3:0] score_p1, score_p2;
  logic [1:0] last_result, match_winner;

  int checks   = 0;
  int failures = 0;
  vec_t vq[$];

  match_ctrl #(.TICKS_PER_SEC(4), .RESULT_CYCLES(5), .WIN_SCORE(2)) dut (
    .clk(clk), .rst(rst),
    .start_local(start_local), .start_remote(start_remote),
    .winner_valid(winner_valid), .winner_code(winner_code),
    .game_rst(game_rst), .state(state), .countdown_sec(countdown_sec),
    .ready_local(ready_local), .ready_remote(ready_remote),
    .score_p1(score_p1), .score_p2(score_p2),
    .last_result(last_result), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [2:0] st, input logic grst, input logic [1:0] cd,
                              input logic rl, input logic rr, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [1:0] lr, input logic [1:0] mw);
    out_t o;
    o = '{st: st, grst: grst, cd: cd, rl: rl, rr: rr, s1: s1, s2: s2, lr: lr, mw: mw};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{st: state, grst: game_rst, cd: countdown_sec, rl: ready_local, rr: ready_remote,
          s1: score_p1, s2: score_p2, lr: last_result, mw: match_winner};
    return o;
  endfunction

  task automatic check(input string tag, input int idx, input out_t exp);
    out_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got st=%0d grst=%b cd=%0d rdy=%b%b s=%0d/%0d lr=%b mw=%b, want st=%0d grst=%b cd=%0d rdy=%b%b s=%0d/%0d lr=%b mw=%b",
               tag, idx, got.st, got.grst, got.cd, got.rl, got.rr, got.s1, got.s2, got.lr, got.mw,
               exp.st, exp.grst, exp.cd, exp.rl, exp.rr, exp.s1, exp.s2, exp.lr, exp.mw);
    end
  endtask

  // Drive one cycle of inputs, clock once, check registered outputs
  task automatic apply(input string tag, input int idx, input vec_t v);
    start_local  = v.sl;
    start_remote = v.sr;
    winner_valid = v.wv;
    winner_code  = v.wc;
    @(posedge clk);
    #1;
    check(tag, idx, v.exp);
  endtask

  function automatic void push(input logic sl, input logic sr, input logic wv,
                               input logic [1:0] wc, input out_t exp);
    vec_t v;
    v.sl = sl; v.sr = sr; v.wv = wv; v.wc = wc; v.exp = exp;
    vq.push_back(v);
  endfunction

  // Remaining 11 countdown cycles after entry, then the PLAY entry
  function automatic void push_countdown(input logic [3:0] s1, input logic [3:0] s2,
                                         input logic [1:0] lr);
    for (int k = 1; k <= 11; k++)
      push(0, 0, 0, 2'b00, mk(3'd1, 1, 2'(3 - k / 4), 0, 0, s1, s2, lr, 2'b00));
    push(0, 0, 0, 2'b00, mk(3'd2, 0, 2'd0, 0, 0, s1, s2, lr, 2'b00));
  endfunction

  // Four more ROUND_END cycles after the verdict cycle, then COUNTDOWN entry
  function automatic void push_hold_to_cd(input logic [3:0] s1, input logic [3:0] s2,
                                          input logic [1:0] lr);
    for (int k = 0; k < 4; k++)
      push(0, 0, 0, 2'b00, mk(3'd3, 1, 2'd0, 0, 0, s1, s2, lr, 2'b00));
    push(0, 0, 0, 2'b00, mk(3'd1, 1, 2'd3, 0, 0, s1, s2, lr, 2'b00));
  endfunction

  initial begin
    out_t rst_val;
    vec_t v;
    rst_val = mk(3'd0, 1, 2'd0, 0, 0, 4'd0, 4'd0, 2'b00, 2'b00);

    // Button held across reset must not count as a start
    push(1, 0, 0, 2'b00, rst_val);
    push(1, 0, 0, 2'b00, rst_val);
    push(0, 0, 0, 2'b00, rst_val);
    push(1, 0, 0, 2'b00, mk(3'd0, 1, 2'd0, 1, 0, 4'd0, 4'd0, 2'b00, 2'b00));
    push(0, 0, 0, 2'b00, mk(3'd0, 1, 2'd0, 1, 0, 4'd0, 4'd0, 2'b00, 2'b00));
    push(0, 0, 0, 2'b00, mk(3'd0, 1, 2'd0, 1, 0, 4'd0, 4'd0, 2'b00, 2'b00));
    push(0, 1, 0, 2'b00, mk(3'd1, 1, 2'd3, 0, 0, 4'd0, 4'd0, 2'b00, 2'b00));
    push_countdown(4'd0, 4'd0, 2'b00);
    // P1 round win
    push(0, 0, 0, 2'b00, mk(3'd2, 0, 2'd0, 0, 0, 4'd0, 4'd0, 2'b00, 2'b00));
    push(0, 0, 1, 2'b01, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd0, 2'b01, 2'b00));
    push_hold_to_cd(4'd1, 4'd0, 2'b01);
    push_countdown(4'd1, 4'd0, 2'b01);
    // Draw, then a back-to-back strobe that must be ignored
    push(0, 0, 1, 2'b11, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd0, 2'b11, 2'b00));
    push(0, 0, 1, 2'b10, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd0, 2'b11, 2'b00));
    for (int k = 0; k < 3; k++)
      push(0, 0, 0, 2'b00, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd0, 2'b11, 2'b00));
    push(0, 0, 0, 2'b00, mk(3'd1, 1, 2'd3, 0, 0, 4'd1, 4'd0, 2'b11, 2'b00));
    push_countdown(4'd1, 4'd0, 2'b11);
    // Invalid code stays in PLAY, then P2 wins; start edge in ROUND_END not latched
    push(0, 0, 1, 2'b00, mk(3'd2, 0, 2'd0, 0, 0, 4'd1, 4'd0, 2'b11, 2'b00));
    push(0, 0, 1, 2'b10, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd1, 2'b10, 2'b00));
    push(1, 1, 0, 2'b00, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd1, 2'b10, 2'b00));
    for (int k = 0; k < 3; k++)
      push(0, 0, 0, 2'b00, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd1, 2'b10, 2'b00));
    push(0, 0, 0, 2'b00, mk(3'd1, 1, 2'd3, 0, 0, 4'd1, 4'd1, 2'b10, 2'b00));
    push_countdown(4'd1, 4'd1, 2'b10);
    // Second P2 win decides the match
    push(0, 0, 1, 2'b10, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd2, 2'b10, 2'b00));
    for (int k = 0; k < 4; k++)
      push(0, 0, 0, 2'b00, mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd2, 2'b10, 2'b00));
    push(0, 0, 0, 2'b00, mk(3'd4, 1, 2'd0, 0, 0, 4'd1, 4'd2, 2'b10, 2'b10));
    push(0, 0, 1, 2'b01, mk(3'd4, 1, 2'd0, 0, 0, 4'd1, 4'd2, 2'b10, 2'b10));
    // Re-arm in MATCH_END clears the match
    push(1, 0, 0, 2'b00, mk(3'd4, 1, 2'd0, 1, 0, 4'd1, 4'd2, 2'b10, 2'b10));
    push(0, 1, 0, 2'b00, mk(3'd1, 1, 2'd3, 0, 0, 4'd0, 4'd0, 2'b00, 2'b00));
    push_countdown(4'd0, 4'd0, 2'b00);

    rst = 1'b1;
    start_local = 1'b1; start_remote = 1'b0; winner_valid = 1'b0; winner_code = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, rst_val);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply("table", i, vq[i]);

    // Hand sequence: P1 win, hold, then simultaneous start edges are irrelevant here;
    // reach COUNTDOWN with score_p1=1 and hit reset mid-second
    v.sl = 0; v.sr = 0; v.wv = 1; v.wc = 2'b01;
    v.exp = mk(3'd3, 1, 2'd0, 0, 0, 4'd1, 4'd0, 2'b01, 2'b00);
    apply("p1win", 0, v);
    v.wv = 0; v.wc = 2'b00;
    for (int k = 0; k < 4; k++) apply("hold", k, v);
    v.exp = mk(3'd1, 1, 2'd3, 0, 0, 4'd1, 4'd0, 2'b01, 2'b00);
    apply("cd_entry", 0, v);
    apply("cd_mid", 0, v);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, rst_val);
    @(posedge clk);
    #1;
    check("rst_held", 0, rst_val);
    rst = 1'b0;

    // Hand sequence: both edges in the same IDLE cycle
    v.sl = 0; v.sr = 0; v.exp = rst_val;
    apply("idle_low", 0, v);
    v.sl = 1; v.sr = 1;
    v.exp = mk(3'd1, 1, 2'd3, 0, 0, 4'd0, 4'd0, 2'b00, 2'b00);
    apply("dual_edge", 0, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
